md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Execute-stage multiply/divide unit for the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and holds the HI/LO architectural registers.
- Drives the XALU result that is latched into the E/M register, and a busy flag for the hazard unit's D-stage stall.
- Supports cancellation of an in-flight operation when the issuing instruction takes an exception in M.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD family); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage instruction issues `op` this cycle.
- op  input  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 NOP.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- rd_hi  input  1  1 selects HI on `out`; 0 selects LO.
- cancel  input  1  abort the in-flight operation (exception or eret seen in M).
- busy  output  1  operation in flight.
- out  output  32  combinational, rd_hi ? HI : LO, committed values only.

Behaviour:
- Reset: HI=0, LO=0, busy=0, internal counter=0, pending result=0. Reset overrides start and cancel in the same cycle.
- Accept rule: an op is accepted at a rising edge when start=1, busy=0 and cancel=0. Otherwise start is ignored; no queueing.
- Mult/div issue: on acceptance, compute the 64-bit result from A and B and store it in a pending register. Set busy=1 and counter=N (N = MULT_CYCLES or DIV_CYCLES).
- Busy window: busy stays high for exactly N cycles after the accepting edge. Counter decrements each edge.
- Commit: at the edge where counter goes 1->0, write pending into {HI,LO} and clear busy. New values are visible on `out` in the first cycle that busy=0.
- MULT: {HI,LO} = signed 32x32 -> 64 product.
- MULTU: {HI,LO} = unsigned 32x32 -> 64 product.
- DIV/DIVU: LO = quotient, HI = remainder. Signed quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (B=0) for DIV/DIVU: accepted and busy for DIV_CYCLES, but HI/LO are left unchanged at commit.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: on acceptance, HI (resp. LO) = A at the same edge. busy stays 0; the other register is untouched.
- NOP codes: no effect even when accepted.
- Cancel while busy: at the next edge busy=0, counter=0, pending discarded, HI/LO keep their pre-issue values.
- Cancel while idle: no effect. An MTHI/MTLO already written is not undone; the hazard unit never issues MTHI/MTLO in the cycle before an M-stage exception can cancel it.
- start with cancel in the same cycle: start is ignored.
- Back-to-back: a start in the first cycle busy=0 after a commit is accepted and operates on the committed HI/LO (relevant for MADD).
- `out` never reflects pending (uncommitted) data.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined:
  - op 7/8 (MADD/MADDU): {HI,LO} += signed/unsigned A*B.
  - op 9/10 (MSUB/MSUBU): {HI,LO} -= signed/unsigned A*B.
  - Accumulate uses the {HI,LO} value at the accepting edge, modulo 2^64, with MULT_CYCLES latency. Cancel restores as for MULT.
- Not defined: op 7-10 are NOPs (busy stays 0, HI/LO unchanged). No accumulator adder is synthesized.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE(-2), B=3 -> busy high for exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA; out=LO with rd_hi=0.
- DIV A=0xFFFFFFF9(-7), B=2 -> busy for 10 cycles; LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
- MTHI A=0x12345678 with HI=LO=0 -> next cycle HI=0x12345678, LO=0, busy never asserts. Then DIVU B=0 -> busy 10 cycles, HI/LO unchanged.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, cancel asserted 1 cycle after acceptance -> busy=0 at the next edge, HI/LO keep their prior values. start held during busy is ignored (busy does not restart).
- start and reset together mid-operation (busy=1, counter=3) -> after the edge busy=0, HI=LO=0, op not accepted.
- With MD_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without MD_MADD_EN the same op -> busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/md_unit.sv
// MIPS E-stage multiply/divide unit holding HI/LO; MULT_CYCLES/DIV_CYCLES busy latency, start ignored while busy or cancelled.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are built only when MD_MADD_EN is defined.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_hi,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam logic [3:0] MUL_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] pending;
    logic [3:0]  cnt;

    logic        mul_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    // Low 64 bits of the extended operands' product equal the signed or unsigned 32x32 product.
    always_comb begin
        mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
        a_ext      = {{32{mul_signed & A[31]}}, A};
        b_ext      = {{32{mul_signed & B[31]}}, B};
        prod       = a_ext * b_ext;
    end

    // Sign-magnitude division: quotient truncates toward zero, remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    always_comb begin
        div_signed = (op == OP_DIV);
        a_neg      = div_signed & A[31];
        b_neg      = div_signed & B[31];
        abs_a      = a_neg ? (32'd0 - A) : A;
        abs_b      = b_neg ? (32'd0 - B) : B;
        divisor    = (B == 32'd0) ? 32'd1 : abs_b;
        q_mag      = abs_a / divisor;
        r_mag      = abs_a % divisor;
        quo        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem        = a_neg ? (32'd0 - r_mag) : r_mag;
    end

`ifdef MD_MADD_EN
    logic [63:0] acc_add;
    logic [63:0] acc_sub;

    always_comb begin
        acc_add = {hi, lo} + prod;
        acc_sub = {hi, lo} - prod;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            busy    <= 1'b0;
            cnt     <= 4'd0;
            pending <= 64'd0;
        end else if (busy) begin
            if (cancel) begin
                busy    <= 1'b0;
                cnt     <= 4'd0;
                pending <= 64'd0;
            end else begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    {hi, lo} <= pending;
                    busy     <= 1'b0;
                end
            end
        end else if (start && !cancel) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    pending <= prod;
                    busy    <= 1'b1;
                    cnt     <= MUL_N;
                end
                OP_DIV, OP_DIVU: begin
                    // HI/LO cannot change while busy, so a divide by zero just recommits them.
                    pending <= (B == 32'd0) ? {hi, lo} : {rem, quo};
                    busy    <= 1'b1;
                    cnt     <= DIV_N;
                end
                OP_MTHI: hi <= A;
                OP_MTLO: lo <= A;
`ifdef MD_MADD_EN
                OP_MADD, OP_MADDU: begin
                    pending <= acc_add;
                    busy    <= 1'b1;
                    cnt     <= MUL_N;
                end
                OP_MSUB, OP_MSUBU: begin
                    pending <= acc_sub;
                    busy    <= 1'b1;
                    cnt     <= MUL_N;
                end
`endif
                default: ;
            endcase
        end
    end

    assign out = rd_hi ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed-vector bench for md_unit with hand-computed HI/LO/busy expectations.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_hi;
    logic        cancel;
    logic        busy;
    logic [31:0] out;

    int n_vec = 0;
    int n_err = 0;
    int cyc;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .rd_hi  (rd_hi),
        .cancel (cancel),
        .busy   (busy),
        .out    (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_hl(input string tag, input logic [31:0] eh, input logic [31:0] el);
        rd_hi = 1'b1;
        #1;
        chk({tag, "_hi"}, 64'(out), 64'(eh));
        rd_hi = 1'b0;
        #1;
        chk({tag, "_lo"}, 64'(out), 64'(el));
    endtask

    // Issue one op; returns the number of cycles busy stayed high after the accepting edge.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        op = o; A = a; B = b; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 4'd0; A = '0; B = '0; rd_hi = 1'b0; cancel = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd1 - 64'd1);
        chk_hl("rst", 32'h0, 32'h0);

        // MULT -2*3 with out held at the old LO while busy
        op = 4'd1; A = 32'hFFFFFFFE; B = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        chk("mult_busy_acc", 64'(busy), 64'd1);
        chk("mult_out_pend", 64'(out), 64'd0);
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            step();
        end
        chk("mult_cycles", 64'(cyc), 64'd5);
        chk_hl("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

        run_op(4'd3, 32'hFFFFFFF9, 32'd2, cyc);
        chk("div_cycles", 64'(cyc), 64'd10);
        chk_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

        run_op(4'd4, 32'hFFFFFFF9, 32'd2, cyc);
        chk_hl("divu", 32'h00000001, 32'h7FFFFFFC);

        run_op(4'd3, 32'd7, 32'hFFFFFFFE, cyc);
        chk_hl("div_pos_neg", 32'h00000001, 32'hFFFFFFFD);

        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, cyc);
        chk_hl("div_ovf", 32'h00000000, 32'h80000000);

        // reset together with start while counter=3
        op = 4'd1; A = 32'd2; B = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("rstmid_busy_pre", 64'(busy), 64'd1);
        reset = 1'b1; start = 1'b1;
        step();
        reset = 1'b0; start = 1'b0;
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk_hl("rstmid", 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) step();
        chk("rstmid_busy_late", 64'(busy), 64'd0);
        chk_hl("rstmid_late", 32'h0, 32'h0);

        run_op(4'd5, 32'h12345678, 32'd0, cyc);
        chk("mthi_cycles", 64'(cyc), 64'd0);
        chk_hl("mthi", 32'h12345678, 32'h0);
        run_op(4'd6, 32'hCAFEF00D, 32'd0, cyc);
        chk_hl("mtlo", 32'h12345678, 32'hCAFEF00D);

        run_op(4'd4, 32'd99, 32'd0, cyc);
        chk("div0_cycles", 64'(cyc), 64'd10);
        chk_hl("div0", 32'h12345678, 32'hCAFEF00D);

        // cancel one cycle after acceptance, start held alongside
        op = 4'd2; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; start = 1'b1;
        step();
        chk("cancel_busy_acc", 64'(busy), 64'd1);
        cancel = 1'b1;
        step();
        chk("cancel_busy", 64'(busy), 64'd0);
        cancel = 1'b0; start = 1'b0;
        chk_hl("cancel", 32'h12345678, 32'hCAFEF00D);
        step();
        chk("cancel_busy_after", 64'(busy), 64'd0);
        for (int i = 0; i < 6; i++) step();
        chk_hl("cancel_late", 32'h12345678, 32'hCAFEF00D);

        // start held through part of the busy window must not restart it
        op = 4'd2; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; start = 1'b1;
        step();
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            cyc++;
            step();
        end
        start = 1'b0;
        while (busy && cyc < 40) begin
            cyc++;
            step();
        end
        chk("hold_cycles", 64'(cyc), 64'd5);
        chk_hl("multu_max", 32'hFFFFFFFE, 32'h00000001);

        // start with cancel while idle is ignored
        op = 4'd1; A = 32'd5; B = 32'd5; start = 1'b1; cancel = 1'b1;
        step();
        start = 1'b0; cancel = 1'b0;
        chk("startcancel_busy", 64'(busy), 64'd0);
        chk_hl("startcancel", 32'hFFFFFFFE, 32'h00000001);

        run_op(4'd0, 32'd7, 32'd7, cyc);
        chk("nop0_cycles", 64'(cyc), 64'd0);
        run_op(4'd11, 32'd7, 32'd7, cyc);
        chk("nop11_cycles", 64'(cyc), 64'd0);
        chk_hl("nop", 32'hFFFFFFFE, 32'h00000001);

        run_op(4'd5, 32'h0, 32'd0, cyc);
        run_op(4'd6, 32'hFFFFFFFF, 32'd0, cyc);
        run_op(4'd8, 32'd1, 32'd1, cyc);
`ifdef MD_MADD_EN
        chk("maddu_cycles", 64'(cyc), 64'd5);
        chk_hl("maddu", 32'h00000001, 32'h00000000);
        // back-to-back MSUB on the just-committed value: 0x1_00000000 - (-2*3)
        run_op(4'd9, 32'hFFFFFFFE, 32'd3, cyc);
        chk("msub_cycles", 64'(cyc), 64'd5);
        chk_hl("msub", 32'h00000001, 32'h00000006);
`else
        chk("maddu_cycles", 64'(cyc), 64'd0);
        chk_hl("maddu", 32'h00000000, 32'hFFFFFFFF);
        run_op(4'd9, 32'hFFFFFFFE, 32'd3, cyc);
        chk("msub_cycles", 64'(cyc), 64'd0);
        chk_hl("msub", 32'h00000000, 32'hFFFFFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
